// File: rtl/glb_tile_event_ctrl_pkg.sv
// Shared global-buffer parameters: tile count, event-controller register map
// and interrupt-enable bit positions.
package global_buffer_param;

    localparam int NUM_GLB_TILES = 16;

    localparam logic [2:0] EVT_STRM_START = 3'd0;
    localparam logic [2:0] EVT_PC_START   = 3'd1;
    localparam logic [2:0] EVT_F2G_STAT   = 3'd2;
    localparam logic [2:0] EVT_G2F_STAT   = 3'd3;
    localparam logic [2:0] EVT_PCFG_STAT  = 3'd4;
    localparam logic [2:0] EVT_IER        = 3'd5;
    localparam logic [2:0] EVT_BUSY       = 3'd6;
    localparam logic [2:0] EVT_ERR        = 3'd7;

    localparam int IER_F2G  = 0;
    localparam int IER_G2F  = 1;
    localparam int IER_PCFG = 2;

endpackage

// File: rtl/glb_tile_event_ctrl_status_reg.sv
// Sticky write-1-to-clear status register; a set on the same edge as a clear wins.
module glb_evt_status_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] set,
    input  logic [WIDTH-1:0] clr,
    output logic [WIDTH-1:0] stat,
    output logic             any
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat <= '0;
        end else begin
            stat <= (stat & ~clr) | set;
        end
    end

    assign any = |stat;

endmodule

// File: rtl/glb_tile_event_ctrl.sv
// Per-tile start-pulse generation with busy tracking, sticky interrupt status
// and a register-mapped config port for the GLB tile row.
module glb_tile_event_ctrl #(
    parameter int NUM_GLB_TILES  = global_buffer_param::NUM_GLB_TILES,
    parameter int CFG_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_wr_en,
    input  logic                      cfg_rd_en,
    input  logic [2:0]                cfg_addr,
    input  logic [CFG_DATA_WIDTH-1:0] cfg_wr_data,
    output logic [CFG_DATA_WIDTH-1:0] cfg_rd_data,
    output logic                      cfg_rd_data_valid,
    output logic [NUM_GLB_TILES-1:0]  strm_start_pulse,
    output logic [NUM_GLB_TILES-1:0]  pc_start_pulse,
    input  logic [NUM_GLB_TILES-1:0]  strm_f2g_interrupt_pulse,
    input  logic [NUM_GLB_TILES-1:0]  strm_g2f_interrupt_pulse,
    input  logic [NUM_GLB_TILES-1:0]  pcfg_g2f_interrupt_pulse,
    output logic                      interrupt
);
    import global_buffer_param::*;

    logic [NUM_GLB_TILES-1:0]  wr_tiles;
    logic [NUM_GLB_TILES-1:0]  strm_req, strm_grant, strm_busy, strm_done;
    logic [NUM_GLB_TILES-1:0]  pc_req, pc_grant, pc_busy;
    logic [NUM_GLB_TILES-1:0]  f2g_clr, g2f_clr, pcfg_clr;
    logic [NUM_GLB_TILES-1:0]  f2g_stat, g2f_stat, pcfg_stat;
    logic                      f2g_any, g2f_any, pcfg_any;
    logic [2:0]                ier;
    logic [1:0]                err, err_set, err_clr;
    logic                      wr_ok, rd_ok;
    logic [CFG_DATA_WIDTH-1:0] rd_mux;
    logic                      unused_wr_bits;

    assign wr_ok    = cfg_wr_en;
    assign rd_ok    = cfg_rd_en & ~cfg_wr_en;
    assign wr_tiles = cfg_wr_data[NUM_GLB_TILES-1:0];
    assign unused_wr_bits = ^cfg_wr_data[CFG_DATA_WIDTH-1:NUM_GLB_TILES];

    assign strm_req  = (wr_ok && cfg_addr == EVT_STRM_START) ? wr_tiles : '0;
    assign pc_req    = (wr_ok && cfg_addr == EVT_PC_START)   ? wr_tiles : '0;
    assign strm_done = strm_f2g_interrupt_pulse | strm_g2f_interrupt_pulse;

    // Grant is judged on the pre-edge busy bit, so a same-edge done cannot rescue a refused request.
    assign strm_grant = strm_req & ~strm_busy;
    assign pc_grant   = pc_req & ~pc_busy;
    assign err_set    = {|(pc_req & pc_busy), |(strm_req & strm_busy)};
    assign err_clr    = (wr_ok && cfg_addr == EVT_ERR) ? cfg_wr_data[1:0] : '0;

    assign f2g_clr  = (wr_ok && cfg_addr == EVT_F2G_STAT)  ? wr_tiles : '0;
    assign g2f_clr  = (wr_ok && cfg_addr == EVT_G2F_STAT)  ? wr_tiles : '0;
    assign pcfg_clr = (wr_ok && cfg_addr == EVT_PCFG_STAT) ? wr_tiles : '0;

    glb_evt_status_reg #(.WIDTH(NUM_GLB_TILES)) u_f2g_stat (
        .clk(clk), .reset(reset), .set(strm_f2g_interrupt_pulse), .clr(f2g_clr),
        .stat(f2g_stat), .any(f2g_any)
    );
    glb_evt_status_reg #(.WIDTH(NUM_GLB_TILES)) u_g2f_stat (
        .clk(clk), .reset(reset), .set(strm_g2f_interrupt_pulse), .clr(g2f_clr),
        .stat(g2f_stat), .any(g2f_any)
    );
    glb_evt_status_reg #(.WIDTH(NUM_GLB_TILES)) u_pcfg_stat (
        .clk(clk), .reset(reset), .set(pcfg_g2f_interrupt_pulse), .clr(pcfg_clr),
        .stat(pcfg_stat), .any(pcfg_any)
    );

    always_comb begin
        rd_mux = '0;
        case (cfg_addr)
            EVT_F2G_STAT:  rd_mux[NUM_GLB_TILES-1:0] = f2g_stat;
            EVT_G2F_STAT:  rd_mux[NUM_GLB_TILES-1:0] = g2f_stat;
            EVT_PCFG_STAT: rd_mux[NUM_GLB_TILES-1:0] = pcfg_stat;
            EVT_IER:       rd_mux[2:0] = ier;
            EVT_BUSY: begin
                rd_mux[NUM_GLB_TILES-1:0]   = strm_busy;
                rd_mux[16 +: NUM_GLB_TILES] = pc_busy;
            end
            EVT_ERR:       rd_mux[1:0] = err;
            default:       ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strm_start_pulse  <= '0;
            pc_start_pulse    <= '0;
            strm_busy         <= '0;
            pc_busy           <= '0;
            ier               <= '0;
            err               <= '0;
            interrupt         <= 1'b0;
            cfg_rd_data       <= '0;
            cfg_rd_data_valid <= 1'b0;
        end else begin
            strm_start_pulse <= strm_grant;
            pc_start_pulse   <= pc_grant;
            strm_busy        <= (strm_busy & ~strm_done) | strm_grant;
            pc_busy          <= (pc_busy & ~pcfg_g2f_interrupt_pulse) | pc_grant;
            err              <= (err & ~err_clr) | err_set;
            if (wr_ok && cfg_addr == EVT_IER) begin
                ier <= cfg_wr_data[2:0];
            end
            interrupt <= (f2g_any & ier[IER_F2G]) | (g2f_any & ier[IER_G2F]) |
                         (pcfg_any & ier[IER_PCFG]);
            cfg_rd_data       <= rd_ok ? rd_mux : '0;
            cfg_rd_data_valid <= rd_ok;
        end
    end

endmodule
